// File: rtl/disp_page_sched.sv
// Time-shares one 4-digit display between NUM_SRC 16-bit sources.
// Pages rotate round-robin every DWELL cycles; a freshly updated source is pinned for HOLD cycles.
module disp_page_sched #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DWELL   = 1024,
  parameter int unsigned HOLD    = 4096,
  parameter int unsigned SW      = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_upd,
  input  logic [NUM_SRC-1:0]     src_en,
  input  logic                   freeze,
  output logic [15:0]            disp_num,
  output logic [SW-1:0]          disp_sel,
  output logic                   disp_valid,
  output logic                   pinned
);

  localparam int unsigned CMAX = (DWELL > HOLD) ? DWELL : HOLD;
  localparam int unsigned CW   = $clog2(CMAX);

  typedef enum logic [1:0] {ST_IDLE, ST_ROTATE, ST_PIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_sel, w_sel_nxt;
  logic [CW-1:0]   r_dwell, w_dwell_nxt;
  logic [CW-1:0]   r_hold, w_hold_nxt;
  logic [15:0]     r_shadow [NUM_SRC];

  logic [NUM_SRC-1:0] w_pin_req;
  logic [SW-1:0]      w_low_en;
  logic [SW-1:0]      w_low_pin;
  logic [SW-1:0]      w_next_en;
  logic [SW-1:0]      w_cand;
  int                 w_idx;

  assign w_pin_req = src_upd & src_en;

  // Lowest enabled / requesting index, and circular next-enabled search from sel+1.
  always_comb begin
    w_low_en  = '0;
    w_low_pin = '0;
    w_next_en = r_sel;
    w_idx     = 0;
    w_cand    = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_en[SW'(i)])    w_low_en  = SW'(i);
      if (w_pin_req[SW'(i)]) w_low_pin = SW'(i);
    end
    for (int k = int'(NUM_SRC); k > 0; k--) begin
      w_idx = int'(r_sel) + k;
      if (w_idx >= int'(NUM_SRC)) w_idx = w_idx - int'(NUM_SRC);
      w_cand = SW'(w_idx);
      if (src_en[w_cand]) w_next_en = w_cand;
    end
  end

  // Shadow capture runs independently of state and freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SRC); i++) r_shadow[i] <= 16'd0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++)
        if (src_upd[SW'(i)]) r_shadow[i] <= src_data[16*i +: 16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_dwell <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_dwell <= w_dwell_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Priority: all-disabled, pin request, current page disabled, then freeze-gated counting.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_dwell_nxt = r_dwell;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|src_en) begin
          w_state_nxt = ST_ROTATE;
          w_sel_nxt   = w_low_en;
          w_dwell_nxt = '0;
        end
      end
      default: begin
        if (src_en == '0) begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
          w_dwell_nxt = '0;
          w_hold_nxt  = '0;
        end else if (!freeze && (|w_pin_req)) begin
          w_state_nxt = ST_PIN;
          w_sel_nxt   = w_low_pin;
          w_hold_nxt  = '0;
        end else if (!src_en[r_sel]) begin
          w_state_nxt = ST_ROTATE;
          w_sel_nxt   = w_next_en;
          w_dwell_nxt = '0;
        end else if (!freeze) begin
          if (r_state == ST_ROTATE) begin
            if (r_dwell == CW'(DWELL - 1)) begin
              w_sel_nxt   = w_next_en;
              w_dwell_nxt = '0;
            end else begin
              w_dwell_nxt = r_dwell + CW'(1);
            end
          end else begin
            if (r_hold == CW'(HOLD - 1)) begin
              w_state_nxt = ST_ROTATE;
              w_sel_nxt   = w_next_en;
              w_dwell_nxt = '0;
            end else begin
              w_hold_nxt = r_hold + CW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_num   <= 16'd0;
      disp_sel   <= '0;
      disp_valid <= 1'b0;
      pinned     <= 1'b0;
    end else begin
      disp_num   <= (r_state == ST_IDLE) ? 16'd0 : r_shadow[r_sel];
      disp_sel   <= r_sel;
      disp_valid <= (r_state != ST_IDLE);
      pinned     <= (r_state == ST_PIN);
    end
  end

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed self-checking bench for disp_page_sched with DWELL=4, HOLD=8, NUM_SRC=4.
module tb_disp_page_sched;

  logic        clk;
  logic        rst;
  logic [63:0] src_data;
  logic [3:0]  src_upd;
  logic [3:0]  src_en;
  logic        freeze;
  logic [15:0] disp_num;
  logic [1:0]  disp_sel;
  logic        disp_valid;
  logic        pinned;

  int checks;
  int errors;

  disp_page_sched #(.NUM_SRC(4), .DWELL(4), .HOLD(8)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_upd(src_upd),
    .src_en(src_en), .freeze(freeze), .disp_num(disp_num),
    .disp_sel(disp_sel), .disp_valid(disp_valid), .pinned(pinned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; src_upd = '0; src_en = '0; freeze = 1'b0; src_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Reset, load shadows 1111..4444, then enable; the next posedge leaves IDLE.
  task automatic start(input logic [3:0] en);
    do_reset();
    src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_upd  = 4'hF;
    step();
    src_upd  = '0;
    src_en   = en;
  endtask

  task automatic test_reset();
    logic [1:0]  es;
    logic [15:0] en_num;
    rst = 1'b1; src_upd = '0; src_en = '0; freeze = 1'b0; src_data = '0;
    step();
    checks++;
    if ({disp_num, disp_sel, disp_valid, pinned} !== 20'd0) begin
      errors++; $display("FAIL reset_outputs got num=%h sel=%0d v=%b p=%b exp all 0",
                         disp_num, disp_sel, disp_valid, pinned);
    end
    rst = 1'b0;
    src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_upd = 4'hF;
    step();
    src_upd = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (disp_valid !== 1'b0 || disp_num !== 16'd0) begin
        errors++; $display("FAIL idle_disabled got v=%b num=%h exp v=0 num=0000", disp_valid, disp_num);
      end
    end
    src_en = 4'hF;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL first_valid_latency got %b exp 0", disp_valid);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      es = 2'((k - 1) / 4);
      en_num = 16'h1111 * (16'(es) + 16'd1);
      checks++;
      if (disp_sel !== es || disp_num !== en_num || disp_valid !== 1'b1) begin
        errors++; $display("FAIL rotate_all k=%0d got sel=%0d num=%h v=%b exp sel=%0d num=%h v=1",
                           k, disp_sel, disp_num, disp_valid, es, en_num);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [1:0] es;
    start(4'b1010);
    step();
    for (int k = 2; k <= 17; k++) begin
      step();
      es = (((k - 2) / 4) % 2 == 1) ? 2'd3 : 2'd1;
      checks++;
      if (disp_sel !== es || disp_num !== ((es == 2'd3) ? 16'h4444 : 16'h2222)) begin
        errors++; $display("FAIL skip_wrap k=%0d got sel=%0d num=%h exp sel=%0d", k, disp_sel, disp_num, es);
      end
    end
  endtask

  task automatic test_pin();
    start(4'hF);
    step();
    src_data[47:32] = 16'hBEEF;
    src_upd = 4'b0100;
    step();
    src_upd = '0;
    checks++;
    if (disp_sel !== 2'd0 || pinned !== 1'b0) begin
      errors++; $display("FAIL pin_before got sel=%0d p=%b exp sel=0 p=0", disp_sel, pinned);
    end
    for (int n = 3; n <= 10; n++) begin
      step();
      checks++;
      if (disp_sel !== 2'd2 || disp_num !== 16'hBEEF || pinned !== 1'b1) begin
        errors++; $display("FAIL pin_hold n=%0d got sel=%0d num=%h p=%b exp sel=2 num=beef p=1",
                           n, disp_sel, disp_num, pinned);
      end
    end
    step();
    checks++;
    if (disp_sel !== 2'd3 || disp_num !== 16'h4444 || pinned !== 1'b0) begin
      errors++; $display("FAIL pin_exit got sel=%0d num=%h p=%b exp sel=3 num=4444 p=0",
                         disp_sel, disp_num, pinned);
    end
  endtask

  task automatic test_back_to_back();
    start(4'hF);
    step();
    src_data[31:16] = 16'hAAAA;
    src_data[47:32] = 16'hBBBB;
    src_upd = 4'b0110;
    step();
    src_upd = '0;
    for (int n = 3; n <= 6; n++) begin
      step();
      checks++;
      if (disp_sel !== 2'd1 || disp_num !== 16'hAAAA || pinned !== 1'b1) begin
        errors++; $display("FAIL simul_pin n=%0d got sel=%0d num=%h p=%b exp sel=1 num=aaaa p=1",
                           n, disp_sel, disp_num, pinned);
      end
    end
    src_data[47:32] = 16'hCCCC;
    src_upd = 4'b0100;
    step();
    src_upd = '0;
    for (int n = 8; n <= 15; n++) begin
      step();
      checks++;
      if (disp_sel !== 2'd2 || disp_num !== 16'hCCCC || pinned !== 1'b1) begin
        errors++; $display("FAIL repin n=%0d got sel=%0d num=%h p=%b exp sel=2 num=cccc p=1",
                           n, disp_sel, disp_num, pinned);
      end
    end
    step();
    checks++;
    if (disp_sel !== 2'd3 || pinned !== 1'b0) begin
      errors++; $display("FAIL repin_exit got sel=%0d p=%b exp sel=3 p=0", disp_sel, pinned);
    end
  endtask

  task automatic test_freeze_disable();
    start(4'hF);
    step(); step();
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        src_data[63:48] = 16'h5555;
        src_upd = 4'b1000;
      end else begin
        src_upd = '0;
      end
      step();
      checks++;
      if (disp_sel !== 2'd0 || pinned !== 1'b0 || disp_num !== 16'h1111) begin
        errors++; $display("FAIL freeze_hold i=%0d got sel=%0d num=%h p=%b exp sel=0 num=1111 p=0",
                           i, disp_sel, disp_num, pinned);
      end
    end
    src_en = 4'b1000;
    step();
    checks++;
    if (disp_sel !== 2'd0) begin
      errors++; $display("FAIL disable_latency got sel=%0d exp 0", disp_sel);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (disp_sel !== 2'd3 || disp_num !== 16'h5555 || disp_valid !== 1'b1) begin
        errors++; $display("FAIL disable_move i=%0d got sel=%0d num=%h v=%b exp sel=3 num=5555 v=1",
                           i, disp_sel, disp_num, disp_valid);
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_async_reset();
    start(4'hF);
    step();
    src_upd = 4'b0100;
    step();
    src_upd = '0;
    step();
    checks++;
    if (pinned !== 1'b1) begin
      errors++; $display("FAIL areset_setup got p=%b exp 1", pinned);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({disp_num, disp_sel, disp_valid, pinned} !== 20'd0) begin
      errors++; $display("FAIL areset_immediate got num=%h sel=%0d v=%b p=%b exp all 0",
                         disp_num, disp_sel, disp_valid, pinned);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL areset_idle got v=%b exp 0", disp_valid);
    end
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_sel !== 2'd0 || disp_num !== 16'd0 || pinned !== 1'b0) begin
      errors++; $display("FAIL areset_restart got v=%b sel=%0d num=%h p=%b exp v=1 sel=0 num=0000 p=0",
                         disp_valid, disp_sel, disp_num, pinned);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_skip_wrap();
    test_pin();
    test_back_to_back();
    test_freeze_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
